j1_codeload: RTL

- Code memory and boot loader directly upstream of the j1 core's instruction port.
- Holds the core in reset while a firmware image arrives as a byte stream (from a UART receiver), writes it into internal 2^ADDR_W x 16 code RAM, verifies a checksum, then releases the core.
- While the core runs, serves `insn` from `code_addr` with one-cycle registered read latency, which is the timing the core expects.

---
 rtl/j1_codeload.sv | 117 +++++++++++
 1 files changed

// File: rtl/j1_codeload.sv
// Boot loader and code RAM in front of the j1 core: receives a framed firmware
// image over a byte stream, verifies its XOR checksum, then releases the core.
module j1_codeload #(
  parameter int         ADDR_W    = 9,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] code_addr,
  output logic [15:0]       insn,
  output logic              cpu_resetq,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_SYNC, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CSUM, S_RUN
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_cnt_lo, r_lo, r_csum;
  logic [ADDR_W-1:0] r_waddr, r_last;
  logic [ADDR_W:0]   r_words;
  logic              r_err, r_cpu;
  logic [15:0]       r_insn;
  logic [15:0]       r_mem [DEPTH];

  logic              w_accept, w_we, w_cnt_bad, w_last_word;
  logic [15:0]       w_count;

  assign rx_ready     = (r_state != S_RUN);
  assign w_accept     = rx_valid & rx_ready;
  assign w_count      = {rx_data, r_cnt_lo};
  assign w_cnt_bad    = (w_count == 16'd0) || (32'(w_count) > 32'(DEPTH));
  assign w_last_word  = (r_waddr == r_last);
  assign w_we         = w_accept && (r_state == S_DATA_HI);

  assign insn         = r_insn;
  assign cpu_resetq   = r_cpu;
  assign load_err     = r_err;
  assign words_loaded = r_words;

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        S_SYNC:    if (rx_data == SYNC_BYTE) w_next = S_CNT_LO;
        S_CNT_LO:  w_next = S_CNT_HI;
        S_CNT_HI:  w_next = w_cnt_bad ? S_SYNC : S_DATA_LO;
        S_DATA_LO: w_next = S_DATA_HI;
        S_DATA_HI: w_next = w_last_word ? S_CSUM : S_DATA_LO;
        S_CSUM:    w_next = (rx_data == r_csum) ? S_RUN : S_SYNC;
        default:   w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state  <= S_SYNC;
      r_cpu    <= 1'b0;
      r_err    <= 1'b0;
      r_words  <= '0;
      r_csum   <= 8'h00;
      r_waddr  <= '0;
      r_last   <= '0;
      r_cnt_lo <= 8'h00;
      r_lo     <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cpu   <= (r_state == S_RUN);
      if (w_accept) begin
        case (r_state)
          S_SYNC: if (rx_data == SYNC_BYTE) begin
            r_words <= '0;
            r_waddr <= '0;
            r_csum  <= 8'h00;
            r_err   <= 1'b0;
          end
          S_CNT_LO: r_cnt_lo <= rx_data;
          S_CNT_HI: begin
            if (w_cnt_bad) r_err <= 1'b1;
            else           r_last <= ADDR_W'(w_count - 16'd1);
          end
          S_DATA_LO: begin
            r_lo   <= rx_data;
            r_csum <= r_csum ^ rx_data;
          end
          S_DATA_HI: begin
            r_csum  <= r_csum ^ rx_data;
            r_words <= r_words + {{ADDR_W{1'b0}}, 1'b1};
            // hold on the final word so a full-depth image never wraps waddr
            if (!w_last_word) r_waddr <= r_waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          S_CSUM: if (rx_data != r_csum) r_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // RAM is deliberately left out of reset; the read port is read-before-write
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_waddr] <= {rx_data, r_lo};
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_insn <= 16'h0000;
    else         r_insn <= r_mem[code_addr];
  end

endmodule
